adder_arbiter: RTL
==================

// Module: adder_arbiter
//
// PURPOSE
//   Shares a single unsigned adder datapath between NUM_REQ requesters.
//   Round-robin arbitration with valid/ready handshakes on every request port
//   and on the single result port. One-entry result register; full throughput
//   of one sum per cycle when the result consumer never stalls.
//
// PARAMETERS
//   DATA_WIDTH  4  operand width in bits; sum is DATA_WIDTH+1 bits
//   NUM_REQ     2  number of requesters (>=2)
//   ID_W        max(1,$clog2(NUM_REQ))  width of requester index (localparam)
//
// PORTS
//   clk        in   1                     clock, rising edge
//   rst        in   1                     asynchronous reset, active-high
//   req_valid  in   NUM_REQ               request i presents operands
//   req_ready  out  NUM_REQ               one-hot grant; request i accepted this cycle
//   req_a      in   NUM_REQ*DATA_WIDTH    operand A, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_b      in   NUM_REQ*DATA_WIDTH    operand B, same slicing
//   res_valid  out  1                     result register holds a valid sum
//   res_ready  in   1                     consumer accepts result this cycle
//   res_data   out  DATA_WIDTH+1          A+B of the granted request, zero-extended
//   res_id     out  ID_W                  index of requester that produced res_data
//
// BEHAVIOUR
//   - Reset: res_valid=0, res_data=0, res_id=0, RR pointer=0; req_ready=0 while rst.
//   - States: EMPTY (res_valid=0), FULL (res_valid=1). res_valid is the state bit.
//   - can_accept = !res_valid | res_ready  (slot free or being freed this cycle).
//   - Grant (combinational): when can_accept, req_ready = one-hot of first
//     req_valid[i] searching from pointer upward with wrap NUM_REQ-1 -> 0; else all 0.
//   - Transfer on request i when req_valid[i] & req_ready[i]; at next edge:
//     res_data <= {1'b0,A_i}+{1'b0,B_i}, res_id <= i, res_valid <= 1,
//     pointer <= (i==NUM_REQ-1) ? 0 : i+1.
//   - Latency: accept in cycle N -> res_valid high with sum in cycle N+1.
//   - Result accepted (res_valid & res_ready) with no new grant -> res_valid <= 0.
//   - Simultaneous accept-out and grant-in: register reloads, res_valid stays 1.
//   - Backpressure: FULL & !res_ready -> res_data/res_id held stable, req_ready=0.
//   - Pointer unchanged when no grant. No combinational path req_valid -> res_*.
//   - Sum never truncates: carry in res_data[DATA_WIDTH].
//   - Requesters hold req_valid/operands until granted; unused requests ignored.
//   - rst asserted mid-operation: pending result discarded, return to reset values.
//
// TESTING
//   1. req_valid=01, A0=3,B0=4, res_ready=1 -> req_ready=01 cycle N; cycle N+1
//      res_valid=1, res_data=7, res_id=0.
//   2. A0=15,B0=15 (DATA_WIDTH=4) -> res_data=5'b11110 (30), no truncation.
//   3. req_valid=11 held 6 cycles, res_ready=1 -> grants 0,1,0,1,0,1;
//      one result per cycle, res_id alternates.
//   4. FULL with res_data=9, res_ready=0 for 3 cycles, req_valid=11 -> res_data=9,
//      res_id stable, req_ready=00 throughout; res_ready=1 -> next grant same cycle.
//   5. rst pulsed while FULL and req_valid=10 -> res_valid=0 asynchronously;
//      after release first grant goes to requester 1, pointer then 0.
//   6. Random valid/ready stimulus 10k cycles vs. scoreboard model -> every
//      accepted request yields exactly one result, in grant order, correct sum.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one unsigned adder between NUM_REQ requesters.
// A single result register (res_valid is the EMPTY/FULL state bit) feeds a valid/ready output.
module adder_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH:0]           res_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] res_id
);

    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CAND_W = ID_W + 1;

    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH:0]   res_data_q, res_data_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

    logic                  can_accept;
    logic                  grant_found;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [CAND_W-1:0]     cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign can_accept = !res_valid_q || res_ready;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found                 = 1'b1;
                grant_idx                   = cand[ID_W-1:0];
                grant_vec[cand[ID_W-1:0]]   = 1'b1;
            end
        end
    end

    assign grant_valid = grant_found && can_accept && !rst;
    assign req_ready   = grant_valid ? grant_vec : '0;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        // A new grant overrides the drain so back-to-back sums keep res_valid high.
        if (grant_valid) begin
            res_valid_d = 1'b1;
            res_data_d  = {1'b0, a_arr[grant_idx]} + {1'b0, b_arr[grant_idx]};
            res_id_d    = grant_idx;
            ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule
